// File: rtl/eth_frame_detector_mem_axi.sv
// AXI4-Lite slave bridging single-beat reads/writes onto the mem_req/mem_ack
// port of the eth_frame_loop script memory. One access in flight at a time,
// round-robin between write and read, early rejection of bad requests and a
// down-counting watchdog on the memory handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | offer ready to one candidate; the cycle after the offer is
//           | the grant cycle, where the request is latched and checked
// ST_ACCESS | mem_req held high; wait for mem_ack or watchdog expiry
// ST_RESP   | bvalid/rvalid held with stable response until accepted
module eth_frame_detector_mem_axi #(
  parameter int C_AXI_WIDTH      = 32,
  parameter int C_AXI_ADDR_WIDTH = 16,
  parameter int C_MEM_ADDR_WIDTH = 15,
  parameter int C_TIMEOUT        = 1023
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_AXI_WIDTH-1:0]        s_axi_wdata,
  input  logic [C_AXI_WIDTH/8-1:0]      s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [C_AXI_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic                          mem_req,
  output logic [C_MEM_ADDR_WIDTH-1:0]   mem_addr,
  output logic                          mem_wenable,
  output logic [C_AXI_WIDTH-1:0]        mem_wdata,
  input  logic [C_AXI_WIDTH-1:0]        mem_rdata,
  input  logic                          mem_ack
);

  // Timer holds C_TIMEOUT-1 down to 0, one count per ACCESS cycle.
  localparam int TW = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [C_MEM_ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(C_MEM_ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [C_AXI_WIDTH/8-1:0] STRB_FULL = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          last_wr;
  logic          wr_cand;
  logic          rd_cand;
  logic          aw_oor;
  logic          ar_oor;

  assign wr_cand = s_axi_awvalid & s_axi_wvalid;
  assign rd_cand = s_axi_arvalid;

  // Addresses beyond the memory window decode to nothing.
  if (C_AXI_ADDR_WIDTH > C_MEM_ADDR_WIDTH) begin : g_range
    assign aw_oor = |s_axi_awaddr[C_AXI_ADDR_WIDTH-1:C_MEM_ADDR_WIDTH];
    assign ar_oor = |s_axi_araddr[C_AXI_ADDR_WIDTH-1:C_MEM_ADDR_WIDTH];
  end else begin : g_full
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
  end

  // Main controller: arbitration, memory handshake, watchdog and responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      timer         <= '0;
      last_wr       <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rvalid  <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_wenable   <= 1'b0;
      mem_wdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_axi_awready && s_axi_awvalid && s_axi_wvalid) begin
            // Write grant cycle.
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_arready <= 1'b0;
            last_wr       <= 1'b1;
            mem_addr      <= s_axi_awaddr[C_MEM_ADDR_WIDTH-1:0] & ALIGN_MASK;
            mem_wdata     <= s_axi_wdata;
            mem_wenable   <= 1'b1;
            s_axi_rdata   <= '0;
            if (aw_oor) begin
              s_axi_bresp  <= RESP_DECERR;
              s_axi_bvalid <= 1'b1;
              state        <= ST_RESP;
            end else if (s_axi_wstrb != STRB_FULL) begin
              // Partial writes are not supported by the script memory.
              s_axi_bresp  <= RESP_SLVERR;
              s_axi_bvalid <= 1'b1;
              state        <= ST_RESP;
            end else begin
              mem_req <= 1'b1;
              timer   <= TW'(C_TIMEOUT - 1);
              state   <= ST_ACCESS;
            end
          end else if (s_axi_arready && s_axi_arvalid) begin
            // Read grant cycle.
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_arready <= 1'b0;
            last_wr       <= 1'b0;
            mem_addr      <= s_axi_araddr[C_MEM_ADDR_WIDTH-1:0] & ALIGN_MASK;
            mem_wdata     <= '0;
            mem_wenable   <= 1'b0;
            s_axi_rdata   <= '0;
            if (ar_oor) begin
              s_axi_rresp  <= RESP_DECERR;
              s_axi_rvalid <= 1'b1;
              state        <= ST_RESP;
            end else begin
              mem_req <= 1'b1;
              timer   <= TW'(C_TIMEOUT - 1);
              state   <= ST_ACCESS;
            end
          end else begin
            // Offer cycle: ready goes out registered, favouring the kind
            // that was not granted last when both are pending.
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_arready <= 1'b0;
            if (wr_cand && (!rd_cand || !last_wr)) begin
              s_axi_awready <= 1'b1;
              s_axi_wready  <= 1'b1;
            end else if (rd_cand) begin
              s_axi_arready <= 1'b1;
            end
          end
        end

        ST_ACCESS: begin
          // An ack in the expiry cycle still completes the access.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= ST_RESP;
            if (mem_wenable) begin
              s_axi_bresp  <= RESP_OKAY;
              s_axi_bvalid <= 1'b1;
            end else begin
              s_axi_rdata  <= mem_rdata;
              s_axi_rresp  <= RESP_OKAY;
              s_axi_rvalid <= 1'b1;
            end
          end else if (timer == '0) begin
            mem_req <= 1'b0;
            state   <= ST_RESP;
            if (mem_wenable) begin
              s_axi_bresp  <= RESP_SLVERR;
              s_axi_bvalid <= 1'b1;
            end else begin
              s_axi_rdata  <= '0;
              s_axi_rresp  <= RESP_SLVERR;
              s_axi_rvalid <= 1'b1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end

        ST_RESP: begin
          if ((s_axi_bvalid && s_axi_bready) || (s_axi_rvalid && s_axi_rready)) begin
            s_axi_bvalid <= 1'b0;
            s_axi_rvalid <= 1'b0;
            state        <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_detector_mem_axi.sv
// Bench for eth_frame_detector_mem_axi: a behavioural memory responder with
// programmable ack delay, directed scenarios and a randomized run checked
// against a transaction-level reference (word memory + latency arithmetic).
module tb_eth_frame_detector_mem_axi;

  localparam int AW  = 16;
  localparam int MW  = 15;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] s_axi_awaddr = '0;
  logic          s_axi_awvalid = 1'b0;
  logic          s_axi_awready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [3:0]    s_axi_wstrb = '0;
  logic          s_axi_wvalid = 1'b0;
  logic          s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready = 1'b0;
  logic [AW-1:0] s_axi_araddr = '0;
  logic          s_axi_arvalid = 1'b0;
  logic          s_axi_arready;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid;
  logic          s_axi_rready = 1'b0;
  logic          mem_req;
  logic [MW-1:0] mem_addr;
  logic          mem_wenable;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack;
  logic          resp_ack = 1'b0;
  logic          spur_ack = 1'b0;

  assign mem_ack = resp_ack | spur_ack;

  eth_frame_detector_mem_axi #(
    .C_AXI_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .C_MEM_ADDR_WIDTH(MW), .C_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wenable(mem_wenable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Responder state (written only by the responder process).
  int            ack_dly = 1;   // ack in the Nth mem_req cycle; 0 = never
  int            req_run = 0;
  int            req_total = 0;
  int            unstable = 0;
  logic [MW-1:0] seen_addr = '0;
  logic          seen_wen = 1'b0;
  logic [DW-1:0] seen_wdata = '0;
  logic [DW-1:0] dev_mem [int];

  // Reference memory (written only by the stimulus process).
  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] init_word(input int w);
    return 32'h5A00_0000 ^ (32'(w) * 32'h0000_9E37);
  endfunction

  function automatic int word_of(input logic [AW-1:0] a);
    return int'(a[MW-1:2]);
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    int w;
    w = word_of(a);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic logic outs_any();
    return |{s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
             s_axi_bresp, s_axi_rresp, s_axi_rdata, mem_req, mem_addr, mem_wenable, mem_wdata};
  endfunction

  // Memory responder: counts request cycles, watches stability, acks after ack_dly.
  always @(negedge clk) begin
    int w;
    resp_ack = 1'b0;
    if (rst_n && mem_req) begin
      req_total = req_total + 1;
      if (req_run > 0 && (mem_addr !== seen_addr || mem_wenable !== seen_wen ||
                          mem_wdata !== seen_wdata))
        unstable = unstable + 1;
      seen_addr  = mem_addr;
      seen_wen   = mem_wenable;
      seen_wdata = mem_wdata;
      req_run    = req_run + 1;
      if (ack_dly != 0 && req_run == ack_dly) begin
        resp_ack = 1'b1;
        w = int'(mem_addr[MW-1:2]);
        if (mem_wenable) dev_mem[w] = mem_wdata;
        else mem_rdata = dev_mem.exists(w) ? dev_mem[w] : init_word(w);
      end
    end else begin
      req_run = 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grant(input bit is_wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (is_wr ? (s_axi_awready && s_axi_wready) : s_axi_arready) begin
        ok = 1'b1;
        break;
      end
    end
    check_val(is_wr ? "wr_grant_seen" : "rd_grant_seen", 32'(ok), 32'd1);
  endtask

  // One complete transaction, checked against the reference rules.
  task automatic do_txn(input bit is_wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [3:0] strb, input int dly, input int hold, input bit spur);
    int g, vc, req0, req1, unst0, eff;
    bit ok, oor, bad, acked;
    logic [1:0]    eresp, gresp;
    logic [DW-1:0] edata, gdata;

    ack_dly = dly;
    if (is_wr) begin
      s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    end else begin
      s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    end
    wait_grant(is_wr, ok);
    if (ok) begin
      g = cyc; req0 = req_total; unst0 = unstable;
      check_val("grant_exclusive",
                32'(is_wr ? s_axi_arready : (s_axi_awready | s_axi_wready)), 32'd0);
    end
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    if (!ok) return;

    // Reference outcome.
    oor   = (32'(addr) >= (32'd1 << MW));
    bad   = is_wr && (strb != 4'hF);
    acked = (dly >= 1) && (dly <= TMO);
    eresp = oor ? 2'b11 : bad ? 2'b10 : acked ? 2'b00 : 2'b10;
    eff   = (oor || bad) ? 0 : (acked ? dly : TMO);
    edata = (!is_wr && eresp == 2'b00) ? ref_read(addr) : '0;
    if (is_wr && eresp == 2'b00) ref_mem[word_of(addr)] = data;

    ok = 1'b0;
    for (int i = 0; i < TMO + 20; i++) begin
      if (is_wr ? s_axi_bvalid : s_axi_rvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check_val("resp_valid_seen", 32'(ok), 32'd1);
    if (!ok) return;
    vc    = cyc;
    gresp = is_wr ? s_axi_bresp : s_axi_rresp;
    gdata = s_axi_rdata;
    check_val("latency", 32'(vc - g), 32'(eff + 1));
    check_val(is_wr ? "bresp" : "rresp", 32'(gresp), 32'(eresp));
    if (!is_wr) check_val("rdata", gdata, edata);
    check_val("req_cycles", 32'(req_total - req0), 32'(eff));
    if (eff > 0) begin
      check_val("mem_addr", 32'(seen_addr), 32'(addr[MW-1:0] & 15'h7FFC));
      check_val("mem_wenable", 32'(seen_wen), 32'(is_wr));
      if (is_wr) check_val("mem_wdata", seen_wdata, data);
      check_val("req_stable", 32'(unstable - unst0), 32'd0);
    end

    req1 = req_total;
    for (int i = 0; i < hold; i++) begin
      spur_ack = spur && (i == 0);
      tick();
    end
    spur_ack = 1'b0;
    if (hold > 0) begin
      check_val("hold_valid", 32'(is_wr ? s_axi_bvalid : s_axi_rvalid), 32'd1);
      check_val("hold_resp", 32'(is_wr ? s_axi_bresp : s_axi_rresp), 32'(eresp));
      if (!is_wr) check_val("hold_rdata", s_axi_rdata, edata);
      check_val("hold_no_req", 32'(req_total - req1), 32'd0);
    end
    if (is_wr) s_axi_bready = 1'b1; else s_axi_rready = 1'b1;
    tick();
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    check_val("valid_clear", 32'(s_axi_bvalid | s_axi_rvalid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            ok;
    bit            kinds[$];
    int            n_both;
    bit            r_wr;
    bit            r_spur;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_strb;
    logic [DW-1:0] r_data;
    int            r_dly, r_hold;

    // Reset state, with all request valids already high.
    repeat (2) tick();
    check_val("reset_outs", 32'(outs_any()), 32'd0);
    s_axi_awaddr = 16'h0200; s_axi_wdata = 32'hC0FF_EE00; s_axi_wstrb = 4'hF;
    s_axi_araddr = 16'h0200;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    ack_dly = 1;
    tick();
    check_val("reset_outs_valids_high", 32'(outs_any()), 32'd0);

    // Round-robin with everything held: W,R,W,R,W,R.
    rst_n = 1'b1;
    n_both = 0;
    for (int i = 0; i < 300 && kinds.size() < 6; i++) begin
      tick();
      if (s_axi_arready && (s_axi_awready || s_axi_wready)) n_both++;
      if (s_axi_awready && s_axi_wready) kinds.push_back(1'b1);
      else if (s_axi_arready) kinds.push_back(1'b0);
    end
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    repeat (8) tick();
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    ref_mem[word_of(16'h0200)] = 32'hC0FF_EE00;
    check_val("rr_grant_count", 32'(kinds.size()), 32'd6);
    check_val("rr_exclusive", 32'(n_both), 32'd0);
    foreach (kinds[i]) check_val("rr_order", 32'(kinds[i]), 32'((i % 2) == 0));

    // Basic write with single-cycle ack, then read of an unaligned address.
    do_txn(1'b1, 16'h0040, 32'hDEAD_BEEF, 4'hF, 1, 0, 1'b0);
    do_txn(1'b1, 16'h0040, 32'h1234_5678, 4'hF, 3, 1, 1'b0);
    do_txn(1'b0, 16'h0043, '0, 4'h0, 5, 2, 1'b0);
    check_val("read_0x43_value", s_axi_rdata, 32'h1234_5678);

    // Rejected requests.
    do_txn(1'b1, 16'h8000, 32'h1111_1111, 4'hF, 1, 1, 1'b0);
    do_txn(1'b1, 16'h0100, 32'h2222_2222, 4'h3, 1, 0, 1'b0);
    do_txn(1'b0, 16'hFFFC, '0, 4'h0, 1, 0, 1'b0);

    // Timeout with late ack, ack on expiry, then a normal read.
    do_txn(1'b0, 16'h0080, '0, 4'h0, 0, 3, 1'b1);
    do_txn(1'b0, 16'h0080, '0, 4'h0, TMO, 0, 1'b0);
    do_txn(1'b1, 16'h0084, 32'h3333_3333, 4'hF, TMO + 1, 0, 1'b0);
    do_txn(1'b0, 16'h0080, '0, 4'h0, 1, 0, 1'b0);

    // Reset while mem_req is high.
    ack_dly = 0;
    s_axi_araddr = 16'h0044; s_axi_arvalid = 1'b1;
    wait_grant(1'b0, ok);
    tick();
    s_axi_arvalid = 1'b0;
    tick();
    check_val("rst_pre_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rst_during_access", 32'(outs_any()), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset during RESP with bready low.
    s_axi_awaddr = 16'h0048; s_axi_wdata = 32'h4444_4444; s_axi_wstrb = 4'h3;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    wait_grant(1'b1, ok);
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check_val("rst_pre_bvalid", 32'(s_axi_bvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rst_during_resp", 32'(outs_any()), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_txn(1'b0, 16'h0044, '0, 4'h0, 2, 0, 1'b0);
    do_txn(1'b0, 16'h0040, '0, 4'h0, 1, 0, 1'b0);

    // Randomized traffic against the reference.
    for (int k = 0; k < 40; k++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = ($urandom_range(0, 7) == 0) ? (16'h8000 | 16'($urandom_range(0, 32'h7FFF)))
                                           : 16'($urandom_range(0, 255));
      r_strb = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      r_data = $urandom();
      r_dly  = int'($urandom_range(0, 20));
      r_hold = int'($urandom_range(0, 3));
      r_spur = ($urandom_range(0, 2) == 0);
      do_txn(r_wr, r_addr, r_data, r_strb, r_dly, r_hold, r_spur);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
